// File: rtl/zap_tlb_walker_pkg.sv
// Shared types and constants for the ARMv5 page-table walker.
// TLB entry widths and VA slices keep the legacy `ZAP_* macro names.
`ifndef ZAP_SECTION_TLB_WDT
`define ZAP_SECTION_TLB_WDT 44
`endif
`ifndef ZAP_LPAGE_TLB_WDT
`define ZAP_LPAGE_TLB_WDT 52
`endif
`ifndef ZAP_SPAGE_TLB_WDT
`define ZAP_SPAGE_TLB_WDT 56
`endif
`ifndef ZAP_FPAGE_TLB_WDT
`define ZAP_FPAGE_TLB_WDT 58
`endif
`ifndef ZAP_VA__TRANSLATION_INDEX
`define ZAP_VA__TRANSLATION_INDEX 31:20
`endif
`ifndef ZAP_VA__L2_FINE_INDEX
`define ZAP_VA__L2_FINE_INDEX 19:10
`endif
`ifndef ZAP_VA__SECTION_TAG
`define ZAP_VA__SECTION_TAG 31:20
`endif
`ifndef ZAP_VA__LPAGE_TAG
`define ZAP_VA__LPAGE_TAG 31:16
`endif
`ifndef ZAP_VA__SPAGE_TAG
`define ZAP_VA__SPAGE_TAG 31:12
`endif
`ifndef ZAP_VA__FPAGE_TAG
`define ZAP_VA__FPAGE_TAG 31:10
`endif

package zap_tlb_walker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1_FETCH,
      ST_L2_FETCH,
      ST_REFILL,
      ST_FAULT
   } state_t;

   typedef enum logic [2:0] {
      DT_FAULT,
      DT_SECTION,
      DT_COARSE,
      DT_FINE_TBL,
      DT_LARGE,
      DT_SMALL,
      DT_FINE
   } desc_t;

   localparam logic [1:0] L1_FAULT   = 2'b00;
   localparam logic [1:0] L1_COARSE  = 2'b01;
   localparam logic [1:0] L1_SECTION = 2'b10;
   localparam logic [1:0] L1_FINE    = 2'b11;

   localparam logic [1:0] L2_FAULT = 2'b00;
   localparam logic [1:0] L2_LARGE = 2'b01;
   localparam logic [1:0] L2_SMALL = 2'b10;
   localparam logic [1:0] L2_FINE  = 2'b11;

   localparam logic [3:0] FSR_SECTION_TRANSLATION_FAULT = 4'h5;
   localparam logic [3:0] FSR_PAGE_TRANSLATION_FAULT    = 4'h7;
   localparam logic [3:0] FSR_L1_EXT_ABORT              = 4'hC;
   localparam logic [3:0] FSR_L2_EXT_ABORT              = 4'hE;

   localparam int unsigned SECTION_TLB_WDT = `ZAP_SECTION_TLB_WDT;
   localparam int unsigned LPAGE_TLB_WDT   = `ZAP_LPAGE_TLB_WDT;
   localparam int unsigned SPAGE_TLB_WDT   = `ZAP_SPAGE_TLB_WDT;
   localparam int unsigned FPAGE_TLB_WDT   = `ZAP_FPAGE_TLB_WDT;

   // Bit positions in the one-hot TLB write strobe vector.
   localparam int unsigned TLB_SE = 0;
   localparam int unsigned TLB_LP = 1;
   localparam int unsigned TLB_SP = 2;
   localparam int unsigned TLB_FP = 3;

endpackage

// File: rtl/zap_tlb_walker_desc_dec.sv
// Combinational ARMv5 L1/L2 descriptor decoder: classifies the descriptor,
// forms the L2 table address and the translation-fault status.
module zap_tlb_walker_desc_dec
   import zap_tlb_walker_pkg::*;
(
   input  logic [31:0] i_desc,
   input  logic        i_level2,
   input  logic        i_l1_fine,
   input  logic [9:0]  i_va_idx,
   output desc_t       o_type,
   output logic [31:0] o_next_adr,
   output logic        o_fault,
   output logic [3:0]  o_status
);

   logic unused_desc_bits;
   assign unused_desc_bits = ^i_desc[9:2];

   always_comb begin
      o_type     = DT_FAULT;
      o_next_adr = '0;
      o_fault    = 1'b0;
      o_status   = '0;
      if (!i_level2) begin
         unique case (i_desc[1:0])
            L1_FAULT: begin
               o_fault  = 1'b1;
               o_status = FSR_SECTION_TRANSLATION_FAULT;
            end
            L1_SECTION: o_type = DT_SECTION;
            L1_COARSE: begin
               o_type     = DT_COARSE;
               o_next_adr = {i_desc[31:10], i_va_idx[9:2], 2'b00};
            end
            default: begin
               o_type     = DT_FINE_TBL;
               o_next_adr = {i_desc[31:12], i_va_idx, 2'b00};
            end
         endcase
      end else begin
         unique case (i_desc[1:0])
            L2_LARGE: o_type = DT_LARGE;
            L2_SMALL: o_type = DT_SMALL;
            L2_FINE: begin
               // Fine pages only exist under a fine second-level table.
               if (i_l1_fine) begin
                  o_type = DT_FINE;
               end else begin
                  o_fault  = 1'b1;
                  o_status = FSR_PAGE_TRANSLATION_FAULT;
               end
            end
            default: begin
               o_fault  = 1'b1;
               o_status = FSR_PAGE_TRANSLATION_FAULT;
            end
         endcase
      end
   end

endmodule

// File: rtl/zap_tlb_walker.sv
// ARMv5 page-table walker: L1/L2 descriptor fetch, TLB refill or fault report.
// Optional bus watchdog: define ZAP_TLB_WALKER_TIMEOUT_EN (limit MAX_WAIT).
module zap_tlb_walker
   import zap_tlb_walker_pkg::*;
#(
   parameter logic [31:0] MAX_WAIT = 32'd255
) (
   input  logic                            i_clk,
   input  logic                            i_reset_n,
   input  logic                            i_clkena,
   input  logic                            i_walk,
   input  logic [31:0]                     i_va,
   input  logic [17:0]                     i_baddr,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_fault,
   output logic [7:0]                      o_fsr,
   output logic [31:0]                     o_far,
   output logic                            o_wb_cyc,
   output logic                            o_wb_stb,
   output logic [31:0]                     o_wb_adr,
   input  logic                            i_wb_ack,
   input  logic [31:0]                     i_wb_dat,
   output logic                            o_setlb_we,
   output logic                            o_lptlb_we,
   output logic                            o_sptlb_we,
   output logic                            o_fptlb_we,
   output logic [`ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata,
   output logic [`ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
   output logic [`ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
   output logic [`ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata
);

   state_t                     state_q, state_d;
   logic [31:0]                va_q, va_d;
   logic                       cyc_q, cyc_d;
   logic [31:0]                adr_q, adr_d;
   logic [3:0]                 dom_q, dom_d;
   logic                       l1_fine_q, l1_fine_d;
   logic [3:0]                 fstat_q, fstat_d;
   logic [3:0]                 we_q, we_d;
   logic [SECTION_TLB_WDT-1:0] se_wdata_q, se_wdata_d;
   logic [LPAGE_TLB_WDT-1:0]   lp_wdata_q, lp_wdata_d;
   logic [SPAGE_TLB_WDT-1:0]   sp_wdata_q, sp_wdata_d;
   logic [FPAGE_TLB_WDT-1:0]   fp_wdata_q, fp_wdata_d;
   logic                       done_q, done_d;
   logic                       fault_q, fault_d;
   logic [7:0]                 fsr_q, fsr_d;
   logic [31:0]                far_q, far_d;
   logic                       wait_expired;

   desc_t       dec_type;
   logic [31:0] dec_next_adr;
   logic        dec_fault;
   logic [3:0]  dec_status;

   zap_tlb_walker_desc_dec u_desc_dec (
      .i_desc     (i_wb_dat),
      .i_level2   (state_q == ST_L2_FETCH),
      .i_l1_fine  (l1_fine_q),
      .i_va_idx   (va_q[`ZAP_VA__L2_FINE_INDEX]),
      .o_type     (dec_type),
      .o_next_adr (dec_next_adr),
      .o_fault    (dec_fault),
      .o_status   (dec_status)
   );

`ifdef ZAP_TLB_WALKER_TIMEOUT_EN
   logic [31:0] wait_q, wait_d;

   // Counter rests at zero whenever no request is outstanding, so every
   // new request (L1 or L2) starts a fresh count.
   always_comb begin
      wait_d = wait_q;
      if (!cyc_q) begin
         wait_d = '0;
      end else if (!i_wb_ack) begin
         wait_d = wait_q + 32'd1;
      end
   end

   assign wait_expired = cyc_q && !i_wb_ack && ((wait_q + 32'd1) >= MAX_WAIT);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wait_q <= '0;
      end else if (i_clkena) begin
         wait_q <= wait_d;
      end
   end
`else
   logic unused_max_wait;
   assign unused_max_wait = ^MAX_WAIT;
   assign wait_expired    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      va_d       = va_q;
      cyc_d      = cyc_q;
      adr_d      = adr_q;
      dom_d      = dom_q;
      l1_fine_d  = l1_fine_q;
      fstat_d    = fstat_q;
      we_d       = '0;
      se_wdata_d = se_wdata_q;
      lp_wdata_d = lp_wdata_q;
      sp_wdata_d = sp_wdata_q;
      fp_wdata_d = fp_wdata_q;
      done_d     = 1'b0;
      fault_d    = 1'b0;
      fsr_d      = fsr_q;
      far_d      = far_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_walk) begin
               va_d    = i_va;
               cyc_d   = 1'b1;
               adr_d   = {i_baddr, i_va[`ZAP_VA__TRANSLATION_INDEX], 2'b00};
               state_d = ST_L1_FETCH;
            end
         end

         ST_L1_FETCH, ST_L2_FETCH: begin
            if (!cyc_q) begin
               // L2 request is issued one cycle after the L1 ack drops cyc.
               cyc_d = 1'b1;
            end else if (i_wb_ack) begin
               cyc_d = 1'b0;
               if (state_q == ST_L1_FETCH) begin
                  dom_d     = i_wb_dat[8:5];
                  l1_fine_d = (dec_type == DT_FINE_TBL);
               end
               if (dec_fault) begin
                  fstat_d = dec_status;
                  state_d = ST_FAULT;
               end else begin
                  unique case (dec_type)
                     DT_SECTION: begin
                        we_d[TLB_SE] = 1'b1;
                        se_wdata_d   = {va_q[`ZAP_VA__SECTION_TAG], i_wb_dat};
                        state_d      = ST_REFILL;
                     end
                     DT_LARGE: begin
                        we_d[TLB_LP] = 1'b1;
                        lp_wdata_d   = {va_q[`ZAP_VA__LPAGE_TAG], dom_q, i_wb_dat};
                        state_d      = ST_REFILL;
                     end
                     DT_SMALL: begin
                        we_d[TLB_SP] = 1'b1;
                        sp_wdata_d   = {va_q[`ZAP_VA__SPAGE_TAG], dom_q, i_wb_dat};
                        state_d      = ST_REFILL;
                     end
                     DT_FINE: begin
                        we_d[TLB_FP] = 1'b1;
                        fp_wdata_d   = {va_q[`ZAP_VA__FPAGE_TAG], dom_q, i_wb_dat};
                        state_d      = ST_REFILL;
                     end
                     default: begin
                        adr_d   = dec_next_adr;
                        state_d = ST_L2_FETCH;
                     end
                  endcase
               end
            end else if (wait_expired) begin
               cyc_d   = 1'b0;
               state_d = ST_FAULT;
               if (state_q == ST_L1_FETCH) begin
                  fstat_d = FSR_L1_EXT_ABORT;
                  dom_d   = '0;
               end else begin
                  fstat_d = FSR_L2_EXT_ABORT;
               end
            end
         end

         ST_REFILL: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         ST_FAULT: begin
            done_d  = 1'b1;
            fault_d = 1'b1;
            fsr_d   = {dom_q, fstat_q};
            far_d   = va_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         va_q       <= '0;
         cyc_q      <= 1'b0;
         adr_q      <= '0;
         dom_q      <= '0;
         l1_fine_q  <= 1'b0;
         fstat_q    <= '0;
         we_q       <= '0;
         se_wdata_q <= '0;
         lp_wdata_q <= '0;
         sp_wdata_q <= '0;
         fp_wdata_q <= '0;
         done_q     <= 1'b0;
         fault_q    <= 1'b0;
         fsr_q      <= '0;
         far_q      <= '0;
      end else if (i_clkena) begin
         state_q    <= state_d;
         va_q       <= va_d;
         cyc_q      <= cyc_d;
         adr_q      <= adr_d;
         dom_q      <= dom_d;
         l1_fine_q  <= l1_fine_d;
         fstat_q    <= fstat_d;
         we_q       <= we_d;
         se_wdata_q <= se_wdata_d;
         lp_wdata_q <= lp_wdata_d;
         sp_wdata_q <= sp_wdata_d;
         fp_wdata_q <= fp_wdata_d;
         done_q     <= done_d;
         fault_q    <= fault_d;
         fsr_q      <= fsr_d;
         far_q      <= far_d;
      end
   end

   assign o_busy        = (state_q != ST_IDLE);
   assign o_done        = done_q;
   assign o_fault       = fault_q;
   assign o_fsr         = fsr_q;
   assign o_far         = far_q;
   assign o_wb_cyc      = cyc_q;
   assign o_wb_stb      = cyc_q;
   assign o_wb_adr      = adr_q;
   assign o_setlb_we    = we_q[TLB_SE];
   assign o_lptlb_we    = we_q[TLB_LP];
   assign o_sptlb_we    = we_q[TLB_SP];
   assign o_fptlb_we    = we_q[TLB_FP];
   assign o_setlb_wdata = se_wdata_q;
   assign o_lptlb_wdata = lp_wdata_q;
   assign o_sptlb_wdata = sp_wdata_q;
   assign o_fptlb_wdata = fp_wdata_q;

endmodule

// File: tb/tb_zap_tlb_walker.sv
// Directed self-checking bench for zap_tlb_walker with hand-computed vectors.
module tb_zap_tlb_walker;

`ifdef ZAP_TLB_WALKER_TIMEOUT_EN
   localparam logic [31:0] TB_MAX_WAIT = 32'd4;
`else
   localparam logic [31:0] TB_MAX_WAIT = 32'd255;
`endif

   logic                            i_clk = 1'b0;
   logic                            i_reset_n = 1'b0;
   logic                            i_clkena = 1'b1;
   logic                            i_walk = 1'b0;
   logic [31:0]                     i_va = '0;
   logic [17:0]                     i_baddr = '0;
   logic                            o_busy, o_done, o_fault;
   logic [7:0]                      o_fsr;
   logic [31:0]                     o_far;
   logic                            o_wb_cyc, o_wb_stb;
   logic [31:0]                     o_wb_adr;
   logic                            i_wb_ack = 1'b0;
   logic [31:0]                     i_wb_dat = '0;
   logic                            o_setlb_we, o_lptlb_we, o_sptlb_we, o_fptlb_we;
   logic [`ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata;
   logic [`ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata;
   logic [`ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata;
   logic [`ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cycle    = 0;
   int unsigned t_acc    = 0;

   zap_tlb_walker #(.MAX_WAIT(TB_MAX_WAIT)) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_clkena      (i_clkena),
      .i_walk        (i_walk),
      .i_va          (i_va),
      .i_baddr       (i_baddr),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_fault       (o_fault),
      .o_fsr         (o_fsr),
      .o_far         (o_far),
      .o_wb_cyc      (o_wb_cyc),
      .o_wb_stb      (o_wb_stb),
      .o_wb_adr      (o_wb_adr),
      .i_wb_ack      (i_wb_ack),
      .i_wb_dat      (i_wb_dat),
      .o_setlb_we    (o_setlb_we),
      .o_lptlb_we    (o_lptlb_we),
      .o_sptlb_we    (o_sptlb_we),
      .o_fptlb_we    (o_fptlb_we),
      .o_setlb_wdata (o_setlb_wdata),
      .o_lptlb_wdata (o_lptlb_wdata),
      .o_sptlb_wdata (o_sptlb_wdata),
      .o_fptlb_wdata (o_fptlb_wdata)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cycle <= cycle + 1;

   function automatic logic [3:0] we_vec();
      return {o_fptlb_we, o_sptlb_we, o_lptlb_we, o_setlb_we};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_walk(input logic [17:0] base, input logic [31:0] va);
      i_baddr = base;
      i_va    = va;
      i_walk  = 1'b1;
      tick();
      t_acc = cycle;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!o_wb_cyc && n < 16) begin
         tick();
         n++;
      end
      check_eq("bus_req_seen", o_wb_cyc, 1'b1);
   endtask

   // Waits for the request, inserts wait states, then acks for one cycle.
   task automatic serve(input logic [31:0] dat, input int waits, output logic [31:0] adr);
      wait_req();
      adr = o_wb_adr;
      repeat (waits) tick();
      i_wb_ack = 1'b1;
      i_wb_dat = dat;
      tick();
      i_wb_ack = 1'b0;
   endtask

   // Latency counts edges from the accepting edge to the edge that samples o_done.
   task automatic wait_done(output int unsigned lat);
      int n = 0;
      while (!o_done && n < 40) begin
         tick();
         n++;
      end
      check_eq("done_seen", o_done, 1'b1);
      lat    = cycle - t_acc + 1;
      i_walk = 1'b0;
   endtask

   initial begin
      logic [31:0] adr;
      int unsigned lat;
      logic        any_we, any_done;

      // Reset state
      tick();
      tick();
      check_eq("rst_busy", o_busy, 1'b0);
      check_eq("rst_cyc", {o_wb_cyc, o_wb_stb}, 2'b00);
      check_eq("rst_adr", o_wb_adr, 32'h0);
      check_eq("rst_done_fault", {o_done, o_fault}, 2'b00);
      check_eq("rst_fsr_far", {o_fsr, o_far}, 40'h0);
      check_eq("rst_we", we_vec(), 4'h0);
      check_eq("rst_wdata", {o_setlb_wdata, o_lptlb_wdata} | {o_sptlb_wdata, o_fptlb_wdata}, '0);
      i_reset_n = 1'b1;
      tick();

      // Section refill, zero wait states
      start_walk(18'h00001, 32'h1234_5678);
      check_eq("sec_busy", o_busy, 1'b1);
      check_eq("sec_stb", o_wb_stb, 1'b1);
      serve(32'h8000_0C12, 0, adr);
      check_eq("sec_l1_adr", adr, 32'h0000_448C);
      check_eq("sec_cyc_drop", o_wb_cyc, 1'b0);
      check_eq("sec_we", we_vec(), 4'b0001);
      check_eq("sec_wdata", o_setlb_wdata, {12'h123, 32'h8000_0C12});
      wait_done(lat);
      check_eq("sec_latency", lat, 3);
      check_eq("sec_fault", o_fault, 1'b0);
      check_eq("sec_we_after", we_vec(), 4'h0);
      tick();
      check_eq("sec_done_pulse", o_done, 1'b0);

      // Coarse table -> small page
      start_walk(18'h00002, 32'h0003_4ABC);
      serve(32'h0010_0021, 0, adr);
      check_eq("small_l1_adr", adr, 32'h0000_8000);
      serve(32'h5555_5FFE, 0, adr);
      check_eq("small_l2_adr", adr, 32'h0010_00D0);
      check_eq("small_we", we_vec(), 4'b0100);
      check_eq("small_wdata", o_sptlb_wdata, {20'h00034, 4'h1, 32'h5555_5FFE});
      wait_done(lat);
      check_eq("small_latency", lat, 5);
      check_eq("small_fault", o_fault, 1'b0);
      tick();

      // L1 translation fault
      start_walk(18'h00001, 32'hDEAD_BEEF);
      serve(32'h0000_01E0, 0, adr);
      check_eq("l1f_we", we_vec(), 4'h0);
      wait_done(lat);
      check_eq("l1f_latency", lat, 3);
      check_eq("l1f_fault", o_fault, 1'b1);
      check_eq("l1f_fsr", o_fsr, 8'hF5);
      check_eq("l1f_far", o_far, 32'hDEAD_BEEF);
      check_eq("l1f_we_done", we_vec(), 4'h0);
      tick();

      // Coarse table with a fine-page L2 descriptor is a page fault
      start_walk(18'h00003, 32'h0102_3456);
      serve(32'h0020_0141, 0, adr);
      serve(32'h1234_5673, 0, adr);
      check_eq("cfine_l2_adr", adr, 32'h0020_008C);
      check_eq("cfine_we", we_vec(), 4'h0);
      wait_done(lat);
      check_eq("cfine_fault", o_fault, 1'b1);
      check_eq("cfine_fsr", o_fsr, 8'hA7);
      check_eq("cfine_far", o_far, 32'h0102_3456);
      tick();

      // Fine table -> fine page, two wait states on L1
      start_walk(18'h00004, 32'hABCD_EF12);
      serve(32'h0030_0063, 2, adr);
      check_eq("fine_l1_adr", adr, 32'h0001_2AF0);
      serve(32'h9ABC_D00F, 0, adr);
      check_eq("fine_l2_adr", adr, 32'h0030_0DEC);
      check_eq("fine_we", we_vec(), 4'b1000);
      check_eq("fine_wdata", o_fptlb_wdata, {22'h2AF37B, 4'h3, 32'h9ABC_D00F});
      wait_done(lat);
      check_eq("fine_latency", lat, 7);
      check_eq("fine_fault", o_fault, 1'b0);
      tick();

      // Coarse table -> large page
      start_walk(18'h00005, 32'h7654_3210);
      serve(32'h0040_0001, 0, adr);
      serve(32'hCAFE_0001, 0, adr);
      check_eq("large_l2_adr", adr, 32'h0040_010C);
      check_eq("large_we", we_vec(), 4'b0010);
      check_eq("large_wdata", o_lptlb_wdata, {16'h7654, 4'h0, 32'hCAFE_0001});
      wait_done(lat);
      check_eq("large_latency", lat, 5);
      tick();

      // Clock enable low freezes the walker; ack is not sampled meanwhile
      start_walk(18'h3FFFF, 32'hFFF0_0000);
      check_eq("ce_l1_adr", o_wb_adr, 32'hFFFF_FFFC);
      i_clkena = 1'b0;
      i_wb_ack = 1'b1;
      i_wb_dat = 32'h8000_0C12;
      repeat (3) tick();
      check_eq("ce_frozen_cyc", {o_wb_cyc, o_busy}, 2'b11);
      check_eq("ce_frozen_we", we_vec(), 4'h0);
      i_clkena = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      check_eq("ce_we", we_vec(), 4'b0001);
      check_eq("ce_wdata", o_setlb_wdata, {12'hFFF, 32'h8000_0C12});
      wait_done(lat);
      check_eq("ce_latency", lat, 6);
      tick();

`ifdef ZAP_TLB_WALKER_TIMEOUT_EN
      // Watchdog: no ack on L1
      start_walk(18'h00001, 32'h0BAD_F00D);
      repeat (3) tick();
      check_eq("to_cyc_held", o_wb_cyc, 1'b1);
      tick();
      check_eq("to_cyc_drop", o_wb_cyc, 1'b0);
      wait_done(lat);
      check_eq("to_fault", o_fault, 1'b1);
      check_eq("to_fsr", o_fsr, 8'h0C);
      check_eq("to_far", o_far, 32'h0BAD_F00D);
      tick();
`endif

      // Reset during L2 wait states; a late ack afterwards must be ignored
      start_walk(18'h00002, 32'h0003_4ABC);
      serve(32'h0010_0021, 0, adr);
      wait_req();
      repeat (2) tick();
      i_reset_n = 1'b0;
      i_walk    = 1'b0;
      tick();
      check_eq("rstw_cyc", {o_wb_cyc, o_wb_stb}, 2'b00);
      check_eq("rstw_busy", o_busy, 1'b0);
      check_eq("rstw_fsr_far", {o_fsr, o_far}, 40'h0);
      i_reset_n = 1'b1;
      i_wb_ack  = 1'b1;
      i_wb_dat  = 32'h5555_5FFE;
      any_we    = 1'b0;
      any_done  = 1'b0;
      tick();
      i_wb_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         any_we   = any_we | (|we_vec());
         any_done = any_done | o_done;
         tick();
      end
      check_eq("late_ack_we", any_we, 1'b0);
      check_eq("late_ack_done", any_done, 1'b0);
      check_eq("late_ack_busy", o_busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
